regfile: RTL and testbench

- 32 x 32-bit MIPS general-purpose register file. Sits directly downstream of the destination-register select mux.
- Two combinational read ports serve rs/rt from the instruction field. One synchronous write port takes the muxed destination address (rd, rt or $ra) plus write-back data.
- Provides optional same-cycle write-to-read bypass, hardwired $zero and a programmable $sp reset value.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 27 ++
 rtl/regfile.sv | 64 ++++++
 tb/tb_regfile.sv | 129 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared MIPS register-index constants and register file defaults.
package regfile_pkg;

  localparam int unsigned addr_w = 5;
  localparam int unsigned num_regs = 32;

  localparam logic [addr_w-1:0] zero = 5'd0;
  localparam logic [addr_w-1:0] sp   = 5'd29;
  localparam logic [addr_w-1:0] ra   = 5'd31;

  localparam logic [31:0] sp_init_default = 32'h7FFF_EFFC;

endpackage

// File: rtl/regfile_rdport.sv
// Combinational read port: $zero forcing, optional write-first bypass, array select.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic [addr_w-1:0]                 addr,
  input  logic [addr_w-1:0]                 dstaddr,
  input  logic                              wr_en,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic [num_regs-1:0][DATA_W-1:0]   regs,
  output logic [DATA_W-1:0]                 data_c
);

  always_comb begin
    data_c = '0;
    if (addr == zero) begin
      data_c = '0;
    end else if (BYPASS && wr_en && (addr == dstaddr)) begin
      data_c = wdata;
    end else begin
      data_c = regs[addr];
    end
  end

endmodule

// File: rtl/regfile.sv
// 32 x DATA_W MIPS register file: two combinational read ports, one write port, debug port.
module regfile
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(sp_init_default),
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rsaddr,
  input  logic [4:0]        rtaddr,
  input  logic [4:0]        dstaddr,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdata,
  input  logic [4:0]        dbgaddr,
  output logic [DATA_W-1:0] dbgdata
);

  logic [num_regs-1:1][DATA_W-1:0] mem;
  logic [num_regs-1:0][DATA_W-1:0] regs_view;
  logic                            wr_en_c;

  // Bypass is suppressed while reset is held so reads show reset values.
  assign wr_en_c   = regwrite & rst_n;
  assign regs_view = {mem, {DATA_W{1'b0}}};

  // Storage and write port; $zero has no flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(num_regs); i++) begin
        mem[i] <= (addr_w'(i) == sp) ? SP_INIT : '0;
      end
    end else if (regwrite && (dstaddr != zero)) begin
      mem[dstaddr] <= wdata;
    end
  end

  a_dstaddr_known: assert property (@(posedge clk) disable iff (!rst_n)
    regwrite |-> !$isunknown(dstaddr));

  regfile_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rs (
    .addr    (rsaddr),
    .dstaddr (dstaddr),
    .wr_en   (wr_en_c),
    .wdata   (wdata),
    .regs    (regs_view),
    .data_c  (rsdata)
  );

  regfile_rdport #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_rt (
    .addr    (rtaddr),
    .dstaddr (dstaddr),
    .wr_en   (wr_en_c),
    .wdata   (wdata),
    .regs    (regs_view),
    .data_c  (rtdata)
  );

  assign dbgdata = regs_view[dbgaddr];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: bypassing and non-bypassing instances share stimulus.
`timescale 1ns/1ps
module tb_regfile;

  localparam logic [31:0] SP_INIT = 32'h7FFF_EFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rsaddr = '0, rtaddr = '0, dstaddr = '0, dbgaddr = '0;
  logic        regwrite = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rsdata, rtdata, dbgdata;
  logic [31:0] rsdata_nb, rtdata_nb, dbgdata_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rsaddr(rsaddr), .rtaddr(rtaddr),
    .dstaddr(dstaddr), .regwrite(regwrite), .wdata(wdata),
    .rsdata(rsdata), .rtdata(rtdata), .dbgaddr(dbgaddr), .dbgdata(dbgdata)
  );

  regfile #(.BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rsaddr(rsaddr), .rtaddr(rtaddr),
    .dstaddr(dstaddr), .regwrite(regwrite), .wdata(wdata),
    .rsdata(rsdata_nb), .rtdata(rtdata_nb), .dbgaddr(dbgaddr), .dbgdata(dbgdata_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'(i) * 32'h0101_0101;
  endfunction

  initial begin
    // Reset asserted between edges; values must appear without a clock edge.
    #2 rst_n = 1'b0;
    dbgaddr = 5'd29;
    #1 check("rst_sp_immediate", dbgdata, SP_INIT);
    dbgaddr = 5'd0;
    #0.5 check("rst_zero_immediate", dbgdata, 32'h0);
    // Bypass must not leak through while reset is held.
    regwrite = 1'b1; dstaddr = 5'd29; wdata = 32'h5555_AAAA; rsaddr = 5'd29;
    #0.5 check("rst_read_no_bypass", rsdata, SP_INIT);
    regwrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbgaddr = 5'(i);
      #0.1 check($sformatf("rst_dbg[%0d]", i), dbgdata, (i == 29) ? SP_INIT : 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Writes to $zero are ignored.
    @(negedge clk);
    regwrite = 1'b1; dstaddr = 5'd0; wdata = 32'hDEAD_BEEF; rsaddr = 5'd0; dbgaddr = 5'd0;
    #1 check("zero_rs_during_write", rsdata, 32'h0);
    @(negedge clk) regwrite = 1'b0;
    #1 check("zero_rs_after", rsdata, 32'h0);
    check("zero_dbg_after", dbgdata, 32'h0);

    // Link-register write then read back.
    @(negedge clk);
    regwrite = 1'b1; dstaddr = 5'd31; wdata = 32'h1234_5678;
    @(negedge clk) regwrite = 1'b0; rtaddr = 5'd31;
    #1 check("ra_rt", rtdata, 32'h1234_5678);
    dbgaddr = 5'd30;
    #1 check("ra_neighbor30", dbgdata, 32'h0);
    dbgaddr = 5'd1;
    #1 check("ra_neighbor1", dbgdata, 32'h0);

    // Same-cycle bypass on both ports.
    @(negedge clk);
    regwrite = 1'b1; dstaddr = 5'd8; wdata = 32'hA5A5_A5A5;
    rsaddr = 5'd8; rtaddr = 5'd8; dbgaddr = 5'd8;
    #1 check("byp_rs", rsdata, 32'hA5A5_A5A5);
    check("byp_rt", rtdata, 32'hA5A5_A5A5);
    check("byp_dbg_old", dbgdata, 32'h0);
    check("nobyp_rs_before", rsdata_nb, 32'h0);
    check("nobyp_rt_before", rtdata_nb, 32'h0);
    @(negedge clk) regwrite = 1'b0;
    #1 check("nobyp_rs_after", rsdata_nb, 32'hA5A5_A5A5);
    check("nobyp_rt_after", rtdata_nb, 32'hA5A5_A5A5);
    check("byp_dbg_after", dbgdata, 32'hA5A5_A5A5);

    // Reset lands on top of a pending write.
    @(negedge clk);
    regwrite = 1'b1; dstaddr = 5'd29; wdata = 32'hFFFF_0000;
    @(negedge clk) regwrite = 1'b0; dbgaddr = 5'd29;
    #1 check("sp_overwritten", dbgdata, 32'hFFFF_0000);
    @(negedge clk);
    regwrite = 1'b1; dstaddr = 5'd5; wdata = 32'h1;
    #2 rst_n = 1'b0;
    @(negedge clk) regwrite = 1'b0;
    #1 rst_n = 1'b1;
    dbgaddr = 5'd29;
    #1 check("midrst_sp", dbgdata, SP_INIT);
    dbgaddr = 5'd5;
    #1 check("midrst_r5", dbgdata, 32'h0);
    dbgaddr = 5'd8;
    #1 check("midrst_r8", dbgdata, 32'h0);

    // Back-to-back writes to every register.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      regwrite = 1'b1; dstaddr = 5'(i); wdata = pattern(i);
    end
    @(negedge clk) regwrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rsaddr = 5'(i); rtaddr = 5'(31 - i); dbgaddr = 5'(i);
      #1;
      check($sformatf("b2b_rs[%0d]", i), rsdata, pattern(i));
      check($sformatf("b2b_rt[%0d]", 31 - i), rtdata, pattern(31 - i));
      check($sformatf("b2b_dbg[%0d]", i), dbgdata, pattern(i));
      check($sformatf("b2b_nb_rs[%0d]", i), rsdata_nb, pattern(i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
